// File: rtl/mat_wb_ctrl.sv
// Matrix register-file writeback controller: round-robin arbitration between load and GEMM results,
// multi-row RF write sequencing and a one-cycle status release. Optional macro: MAT_WB_EARLY_RELEASE_EN.
//
// state   | meaning
// IDLE    | no transfer in flight, may accept a result
// WRITE   | writing rows 0..ROWS-1 of the latched destination, holding on rf_stall
// RELEASE | wb_write pulse for the latched destination, may accept the next result
module mat_wb_ctrl #(
    parameter int ROWS  = 4,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld_valid,
    input  logic [3:0]       ld_rd,
    output logic             ld_ready,
    input  logic             gemm_valid,
    input  logic [3:0]       gemm_rd,
    output logic             gemm_ready,
    input  logic             rf_stall,
    output logic             rf_wen,
    output logic [3:0]       rf_sel,
    output logic [ROW_W-1:0] rf_row,
    output logic             rf_src,
    output logic             wb_write,
    output logic [3:0]       wb_sel,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

    state_t           state;
    logic             prio;
    logic             src_q;
    logic [3:0]       rd_q;
    logic [ROW_W-1:0] cnt;

    logic can_accept;
    logic grant_ld;
    logic grant_gemm;
    logic accept;
    logic last_beat;

    always_comb begin
`ifdef MAT_WB_EARLY_RELEASE_EN
        can_accept = (state == IDLE) && !RST;
`else
        can_accept = ((state == IDLE) || (state == RELEASE)) && !RST;
`endif
        grant_ld   = ld_valid && (!gemm_valid || !prio);
        grant_gemm = gemm_valid && (!ld_valid || prio);
        ld_ready   = can_accept && grant_ld;
        gemm_ready = can_accept && grant_gemm;
        accept     = ld_ready || gemm_ready;
        last_beat  = (state == WRITE) && !rf_stall && (cnt == ROW_W'(ROWS - 1));
    end

    // Data-path outputs are zeroed outside their qualifying strobe.
    always_comb begin
        rf_wen   = (state == WRITE) && !rf_stall;
        rf_sel   = rf_wen ? rd_q : 4'd0;
        rf_row   = rf_wen ? cnt : '0;
        rf_src   = rf_wen ? src_q : 1'b0;
`ifdef MAT_WB_EARLY_RELEASE_EN
        wb_write = last_beat;
`else
        wb_write = (state == RELEASE);
`endif
        wb_sel   = wb_write ? rd_q : 4'd0;
        busy     = (state != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            prio  <= 1'b0;
            src_q <= 1'b0;
            rd_q  <= 4'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, RELEASE: begin
                    if (accept) begin
                        src_q <= gemm_ready;
                        rd_q  <= gemm_ready ? gemm_rd : ld_rd;
                        cnt   <= '0;
                        // Pointer moves to whichever source lost this grant.
                        prio  <= !gemm_ready;
                        state <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (!rf_stall) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
`ifdef MAT_WB_EARLY_RELEASE_EN
                            state <= IDLE;
`else
                            state <= RELEASE;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_wb_ctrl.sv
// Directed bench for mat_wb_ctrl: reset, single writebacks, alternation, stalls and mid-transfer reset.
module tb_mat_wb_ctrl;
    localparam int ROWS  = 4;
    localparam int ROW_W = 2;
    localparam int P     = ROWS + 1;
`ifdef MAT_WB_EARLY_RELEASE_EN
    localparam int REL = ROWS;
`else
    localparam int REL = ROWS + 1;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ld_valid = 1'b0;
    logic [3:0]       ld_rd = 4'd0;
    logic             ld_ready;
    logic             gemm_valid = 1'b0;
    logic [3:0]       gemm_rd = 4'd0;
    logic             gemm_ready;
    logic             rf_stall = 1'b0;
    logic             rf_wen;
    logic [3:0]       rf_sel;
    logic [ROW_W-1:0] rf_row;
    logic             rf_src;
    logic             wb_write;
    logic [3:0]       wb_sel;
    logic             busy;

    int tests = 0;
    int fails = 0;

    logic             ew, ewb;
    logic [ROW_W-1:0] er;
    logic [3:0]       es, ews;

    mat_wb_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W)) dut (
        .CLK(CLK), .RST(RST),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_ready(ld_ready),
        .gemm_valid(gemm_valid), .gemm_rd(gemm_rd), .gemm_ready(gemm_ready),
        .rf_stall(rf_stall), .rf_wen(rf_wen), .rf_sel(rf_sel), .rf_row(rf_row),
        .rf_src(rf_src), .wb_write(wb_write), .wb_sel(wb_sel), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; ld_valid = 1'b0; gemm_valid = 1'b0; rf_stall = 1'b0;
        cyc(); cyc(); #1;
        tests++;
        if ({ld_ready, gemm_ready, rf_wen, rf_sel, rf_row, rf_src, wb_write, wb_sel, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got wen=%b sel=%0d row=%0d wb=%b wbsel=%0d busy=%b, want all 0",
                     rf_wen, rf_sel, rf_row, wb_write, wb_sel, busy);
        end
        cyc(); RST = 1'b0; #1;
        tests++;
        if (busy !== 1'b0 || wb_write !== 1'b0) begin
            fails++; $display("FAIL reset_idle: busy=%b wb=%b, want 0 0", busy, wb_write);
        end
    endtask

    task automatic test_single_load();
        cyc(); ld_valid = 1'b1; ld_rd = 4'd5; #1;
        tests++;
        if (ld_ready !== 1'b1 || gemm_ready !== 1'b0) begin
            fails++; $display("FAIL load_accept: ld_ready=%b gemm_ready=%b, want 1 0", ld_ready, gemm_ready);
        end
        for (int k = 1; k <= ROWS + 2; k++) begin
            cyc(); ld_valid = 1'b0; #1;
            ew  = (k <= ROWS);
            er  = ew ? ROW_W'(k - 1) : '0;
            es  = ew ? 4'd5 : 4'd0;
            ewb = (k == REL);
            ews = ewb ? 4'd5 : 4'd0;
            tests++;
            if (rf_wen !== ew || rf_row !== er || rf_sel !== es || rf_src !== 1'b0) begin
                fails++;
                $display("FAIL load_write c%0d: wen=%b row=%0d sel=%0d src=%b, want %b %0d %0d 0",
                         k, rf_wen, rf_row, rf_sel, rf_src, ew, er, es);
            end
            tests++;
            if (wb_write !== ewb || wb_sel !== ews) begin
                fails++; $display("FAIL load_release c%0d: wb=%b sel=%0d, want %b %0d", k, wb_write, wb_sel, ewb, ews);
            end
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL load_done_busy: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_gemm_only();
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            tests++;
            if (busy !== 1'b0 || wb_write !== 1'b0 || ld_ready !== 1'b0 || gemm_ready !== 1'b0) begin
                fails++; $display("FAIL idle_quiet: busy=%b wb=%b readies=%b%b, want 0", busy, wb_write, ld_ready, gemm_ready);
            end
        end
        cyc(); gemm_valid = 1'b1; gemm_rd = 4'd11; #1;
        tests++;
        if (gemm_ready !== 1'b1 || ld_ready !== 1'b0) begin
            fails++; $display("FAIL gemm_accept: gemm_ready=%b ld_ready=%b, want 1 0", gemm_ready, ld_ready);
        end
        for (int k = 1; k <= REL; k++) begin
            cyc(); gemm_valid = 1'b0; #1;
            if (k == 1) begin
                tests++;
                if (rf_wen !== 1'b1 || rf_src !== 1'b1 || rf_sel !== 4'd11) begin
                    fails++; $display("FAIL gemm_src: wen=%b src=%b sel=%0d, want 1 1 11", rf_wen, rf_src, rf_sel);
                end
            end
            ewb = (k == REL);
            ews = ewb ? 4'd11 : 4'd0;
            tests++;
            if (wb_write !== ewb || wb_sel !== ews) begin
                fails++; $display("FAIL gemm_release c%0d: wb=%b sel=%0d, want %b %0d", k, wb_write, wb_sel, ewb, ews);
            end
        end
        cyc(); cyc();
    endtask

    task automatic test_back_to_back();
        int m;
        logic el, eg;
        for (int c = 0; c <= 2 * P + REL; c++) begin
            cyc(); ld_valid = 1'b1; gemm_valid = 1'b1; ld_rd = 4'd2; gemm_rd = 4'd9; #1;
            tests++;
            if (ld_ready && gemm_ready) begin
                fails++; $display("FAIL b2b_two_readies c%0d: ld=%b gemm=%b, want at most one", c, ld_ready, gemm_ready);
            end
            el = (c % P == 0) && ((c / P) % 2 == 0);
            eg = (c % P == 0) && ((c / P) % 2 == 1);
            tests++;
            if (ld_ready !== el || gemm_ready !== eg) begin
                fails++; $display("FAIL b2b_grant c%0d: ld=%b gemm=%b, want %b %b", c, ld_ready, gemm_ready, el, eg);
            end
            ewb = (c >= REL) && ((c - REL) % P == 0);
            m   = (c - REL) / P;
            ews = !ewb ? 4'd0 : ((m % 2 == 0) ? 4'd2 : 4'd9);
            tests++;
            if (wb_write !== ewb || wb_sel !== ews) begin
                fails++; $display("FAIL b2b_release c%0d: wb=%b sel=%0d, want %b %0d", c, wb_write, wb_sel, ewb, ews);
            end
        end
        cyc(); ld_valid = 1'b0; gemm_valid = 1'b0;
        for (int i = 0; i < 30 && busy; i++) cyc();
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL b2b_drain_timeout: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_stall();
        cyc(); gemm_valid = 1'b1; gemm_rd = 4'd7; #1;
        tests++;
        if (gemm_ready !== 1'b1) begin
            fails++; $display("FAIL stall_accept: gemm_ready=%b, want 1", gemm_ready);
        end
        for (int c = 1; c <= REL + 4; c++) begin
            cyc(); gemm_valid = 1'b0; rf_stall = (c >= 3 && c <= 5); #1;
            ew  = (c <= ROWS + 3) && !(c >= 3 && c <= 5);
            er  = !ew ? '0 : ((c < 3) ? ROW_W'(c - 1) : ROW_W'(c - 4));
            es  = ew ? 4'd7 : 4'd0;
            ewb = (c == REL + 3);
            ews = ewb ? 4'd7 : 4'd0;
            tests++;
            if (rf_wen !== ew || rf_row !== er || rf_sel !== es) begin
                fails++;
                $display("FAIL stall_write c%0d: wen=%b row=%0d sel=%0d, want %b %0d %0d",
                         c, rf_wen, rf_row, rf_sel, ew, er, es);
            end
            tests++;
            if (wb_write !== ewb || wb_sel !== ews) begin
                fails++; $display("FAIL stall_release c%0d: wb=%b sel=%0d, want %b %0d", c, wb_write, wb_sel, ewb, ews);
            end
        end
        rf_stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        cyc(); ld_valid = 1'b1; ld_rd = 4'd3; #1;
        tests++;
        if (ld_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_accept: ld_ready=%b, want 1", ld_ready);
        end
        cyc(); ld_valid = 1'b0;
        cyc(); RST = 1'b1; #1;
        tests++;
        if (rf_wen !== 1'b1 || rf_row !== ROW_W'(1)) begin
            fails++; $display("FAIL rstmid_row1: wen=%b row=%0d, want 1 1", rf_wen, rf_row);
        end
        cyc(); RST = 1'b0; #1;
        tests++;
        if ({ld_ready, gemm_ready, rf_wen, rf_sel, rf_row, rf_src, wb_write, wb_sel, busy} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: wen=%b sel=%0d row=%0d wb=%b busy=%b, want all 0",
                     rf_wen, rf_sel, rf_row, wb_write, busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc(); #1;
            if (wb_write) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL rstmid_no_release: wb_write seen=%b, want 0", seen);
        end
        cyc(); ld_valid = 1'b1; gemm_valid = 1'b1; ld_rd = 4'd4; gemm_rd = 4'd10; #1;
        tests++;
        if (ld_ready !== 1'b1 || gemm_ready !== 1'b0) begin
            fails++; $display("FAIL rstmid_prio: ld=%b gemm=%b, want 1 0", ld_ready, gemm_ready);
        end
        for (int k = 1; k <= REL; k++) begin
            cyc(); ld_valid = 1'b0; gemm_valid = 1'b0; #1;
        end
        tests++;
        if (wb_write !== 1'b1 || wb_sel !== 4'd4) begin
            fails++; $display("FAIL rstmid_after_release: wb=%b sel=%0d, want 1 4", wb_write, wb_sel);
        end
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_gemm_only();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule
